// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller with tear-free shadow value
// Outputs are registered from next-state values so they line up with the current slot counter.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    blank_lz,
  output logic [3:0]              num,
  output logic                    blank,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             cnt, cnt_nx;
  logic [IW-1:0]             idx, idx_nx;
  logic [4*NUM_DIGITS-1:0]   shadow, shadow_nx, pending;
  logic                      pending_full, pend_full_nx;
  logic                      slot_end, boundary, xfer;
  logic [NUM_DIGITS-1:0]     lz;
  logic [3:0]                nib_nx;
  logic                      guard_nx, suppress_nx;
  logic [NUM_DIGITS-1:0]     en_nx;

  always_comb begin
    slot_end = (cnt == CNT_MAX);
    boundary = slot_end && (idx == IDX_MAX);
    xfer     = value_valid && value_ready;

    cnt_nx = slot_end ? '0 : cnt + 1'b1;
    idx_nx = idx;
    if (slot_end) idx_nx = (idx == IDX_MAX) ? '0 : idx + 1'b1;

    shadow_nx = (boundary && pending_full) ? pending : shadow;

    // A transfer on the boundary edge refills pending after its old content moves out.
    pend_full_nx = pending_full;
    if (boundary) pend_full_nx = 1'b0;
    if (xfer)     pend_full_nx = 1'b1;

    // lz[i]: every digit from the top down to i is zero.
    lz = '0;
    lz[NUM_DIGITS-1] = (shadow_nx[4*NUM_DIGITS-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (shadow_nx[4*i +: 4] == 4'd0);
    end

    nib_nx      = shadow_nx[{idx_nx, 2'b00} +: 4];
    guard_nx    = (cnt_nx < CW'(GUARD));
    suppress_nx = blank_lz && (idx_nx != '0) && lz[idx_nx];
    en_nx       = guard_nx ? '0 : (NUM_DIGITS'(1) << idx_nx);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      idx          <= '0;
      shadow       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      value_ready  <= 1'b1;
      num          <= 4'd0;
      blank        <= 1'b1;
      digit_en     <= '0;
      frame_done   <= 1'b0;
    end else begin
      cnt          <= cnt_nx;
      idx          <= idx_nx;
      shadow       <= shadow_nx;
      if (xfer) pending <= value;
      pending_full <= pend_full_nx;
      value_ready  <= !pend_full_nx;
      num          <= nib_nx;
      blank        <= guard_nx || suppress_nx;
      digit_en     <= en_nx;
      frame_done   <= boundary;
    end
  end

endmodule
